// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// default parameters, active-low hex segment patterns and the slot-state enum.
package seg7_pkg;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_REFRESH_DIV  = 50000;
  localparam int DEF_GUARD_CYCLES = 2;
  localparam int DEF_BLINK_DIV    = 12500000;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Patterns written g..a (bit 0 = segment a), active low; entry n is hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: per-digit slots with an anode-off guard
// interval, leading-zero suppression, per-digit blink and registered pin outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int BLINK_DIV    = DEF_BLINK_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] iVALUE,
  input  logic                    iLOAD,
  input  logic [NUM_DIGITS-1:0]   iBLINK,
  input  logic                    iLZS,
  input  logic [NUM_DIGITS-1:0]   iDP,
  output logic [6:0]              oSEG,
  output logic                    oDP,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oSCAN_WRAP
);

  localparam int SLOT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam slot_state_e RST_STATE = (GUARD_CYCLES > 0) ? ST_GUARD : ST_SHOW;

  logic [4*NUM_DIGITS-1:0] value_sh;
  logic [NUM_DIGITS-1:0]   blink_sh;
  logic                    lzs_sh;

  logic [SLOT_W-1:0]  slot_cnt;
  logic [SLOT_W-1:0]  slot_nxt;
  logic [IDX_W-1:0]   idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               slot_last;
  logic               idx_last;
  logic               blink_last;

  slot_state_e state_q;
  slot_state_e state_d;

  logic [IDX_W-1:0]      msd;
  logic [3:0]            nibble;
  logic [6:0]            hex_seg;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  assign slot_last  = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
  assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));
  assign blink_last = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign slot_nxt   = slot_last ? '0 : slot_cnt + SLOT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      value_sh <= '0;
      blink_sh <= '0;
      lzs_sh   <= 1'b0;
    end else if (iLOAD) begin
      value_sh <= iVALUE;
      blink_sh <= iBLINK;
      lzs_sh   <= iLZS;
    end
  end

  // Scan position: slot counter, digit index and the wrap pulse aligned with idx -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt   <= '0;
      idx        <= '0;
      oSCAN_WRAP <= 1'b0;
    end else begin
      slot_cnt   <= slot_nxt;
      oSCAN_WRAP <= slot_last && idx_last;
      if (slot_last) begin
        idx <= idx_last ? '0 : idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt <= blink_last ? '0 : blink_cnt + BLINK_W'(1);
      if (blink_last) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

  // Highest non-zero nibble; stays 0 for an all-zero value so digit 0 always shows.
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (value_sh[4*i +: 4] != 4'h0) begin
        msd = IDX_W'(i);
      end
    end
  end

  assign nibble = value_sh[{idx, 2'b00} +: 4];
  assign blank  = (lzs_sh && (idx > msd)) || (blink_phase && blink_sh[idx]);

  seg7_hex_lut u_lut (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = (slot_nxt < SLOT_W'(GUARD_CYCLES)) ? ST_GUARD : ST_SHOW;
    an_d    = '1;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    if ((state_q == ST_SHOW) && !blank) begin
      an_d  = ~(NUM_DIGITS'(1) << idx);
      seg_d = hex_seg;
      dp_d  = ~iDP[idx];
    end
  end

  // Pin registers: one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      oAN  <= '1;
      oSEG <= SEG_OFF;
      oDP  <= 1'b1;
    end else begin
      oAN  <= an_d;
      oSEG <= seg_d;
      oDP  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle scoreboard from a time-based reference model,
// a table of display vectors, and hand sequences for reset, blink and mid-slot load.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int BD = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iLOAD = 1'b0;
  logic        iLZS = 1'b0;
  logic [15:0] iVALUE = 16'h0;
  logic [3:0]  iBLINK = 4'h0;
  logic [3:0]  iDP = 4'h0;
  logic [6:0]  oSEG;
  logic        oDP;
  logic [3:0]  oAN;
  logic        oSCAN_WRAP;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC),
    .BLINK_DIV    (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iVALUE     (iVALUE),
    .iLOAD      (iLOAD),
    .iBLINK     (iBLINK),
    .iLZS       (iLZS),
    .iDP        (iDP),
    .oSEG       (oSEG),
    .oDP        (oDP),
    .oAN        (oAN),
    .oSCAN_WRAP (oSCAN_WRAP)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0011000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Reference model: outputs derived from the cycle count since reset release.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       wrap;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned mcyc = 0;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_blk = 4'h0;
  logic        m_lzs = 1'b0;
  bit          m_on = 1'b0;

  task automatic model_step();
    obs_t e;
    int   s;
    int   d;
    bit   ph;
    bit   off;
    if (reset) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, wrap: 1'b0};
      mcyc = 0; m_val = 16'h0; m_blk = 4'h0; m_lzs = 1'b0; m_on = 1'b1;
      exp_q.push_back(e);
    end else if (m_on) begin
      s  = int'(mcyc % RD);
      d  = int'((mcyc / RD) % ND);
      ph = ((mcyc / BD) % 2) == 1;
      e  = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, wrap: ((mcyc % (RD*ND)) == (RD*ND - 1))};
      if (s >= GC) begin
        off = (m_lzs && d > 0 && ((m_val >> (4*d)) == 16'h0)) || (ph && m_blk[d]);
        if (!off) begin
          e.an  = ~(4'b0001 << d);
          e.seg = hex7(m_val[4*d +: 4]);
          e.dp  = ~iDP[d];
        end
      end
      exp_q.push_back(e);
      mcyc++;
      if (iLOAD) begin
        m_val = iVALUE; m_blk = iBLINK; m_lzs = iLZS;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    obs_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scoreboard{an,seg,dp,wrap}", {19'h0, oAN, oSEG, oDP, oSCAN_WRAP}, {19'h0, e});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0]     value;
    logic            lzs;
    logic [3:0]      dp;
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs[7];

  task automatic reset_and_load(input logic [15:0] v, input logic lz,
                                input logic [3:0] bl, input logic [3:0] dp);
    @(posedge clk); #1 reset = 1'b1; iLOAD = 1'b0;
    @(posedge clk); #1;
    chk("reset_an", {28'h0, oAN}, 32'hF);
    chk("reset_seg_dp_wrap", {23'h0, oSEG, oDP, oSCAN_WRAP}, {23'h0, 7'h7F, 1'b1, 1'b0});
    reset = 1'b0; iLOAD = 1'b1; iVALUE = v; iLZS = lz; iBLINK = bl; iDP = dp;
    @(posedge clk); #1 iLOAD = 1'b0;
  endtask

  initial begin
    int ca[4];
    int cs[4];
    int cnt0[3];
    int cntx;
    int k;
    int last_wrap;
    int nwrap;

    vecs[0] = '{16'h12AF, 1'b0, 4'b0000, 4'b1111, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
    vecs[1] = '{16'h0030, 1'b1, 4'b0011, 4'b0011, {7'b1111111, 7'b1111111, 7'b0110000, 7'b1000000}};
    vecs[2] = '{16'h0000, 1'b1, 4'b0000, 4'b0001, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
    vecs[3] = '{16'h0000, 1'b0, 4'b1010, 4'b1111, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vecs[4] = '{16'h8C5B, 1'b1, 4'b0100, 4'b1111, {7'b0000000, 7'b1000110, 7'b0010010, 7'b0000011}};
    vecs[5] = '{16'h0407, 1'b1, 4'b1111, 4'b0111, {7'b1111111, 7'b0011001, 7'b1000000, 7'b1111000}};
    vecs[6] = '{16'h9E6D, 1'b1, 4'b1000, 4'b1111, {7'b0011000, 7'b0000110, 7'b0000010, 7'b0100001}};

    for (int v = 0; v < 7; v++) begin
      reset_and_load(vecs[v].value, vecs[v].lzs, 4'b0000, vecs[v].dp);
      for (int d = 0; d < 4; d++) begin ca[d] = 0; cs[d] = 0; end
      for (int c = 0; c < RD*ND; c++) begin
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
          if (oAN == ~(4'b0001 << d)) begin
            ca[d]++;
            if (oSEG == vecs[v].seg[d]) cs[d]++;
          end
        end
      end
      for (int d = 0; d < 4; d++) begin
        if (vecs[v].lit[d]) chk($sformatf("vec%0d_digit%0d_show_cycles", v, d), cs[d], RD - GC);
        else                chk($sformatf("vec%0d_digit%0d_dark_cycles", v, d), ca[d], 0);
      end
    end

    // Reset during digit 2's SHOW, then first lit digit after release.
    reset_and_load(16'h12AF, 1'b0, 4'b0000, 4'b0000);
    for (int c = 0; c < 20; c++) @(negedge clk);
    chk("midreset_pre_an", {28'h0, oAN}, 32'hB);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_an", {28'h0, oAN}, 32'hF);
    chk("midreset_seg", {25'h0, oSEG}, 32'h7F);
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (oAN != 4'hF) begin k = i; break; end
    end
    chk("release_first_lit_edges", k, GC + 1);
    chk("release_first_lit_an", {28'h0, oAN}, 32'hE);
    chk("release_first_lit_seg", {25'h0, oSEG}, {25'h0, 7'b1000000});

    // Blink on digit 0 only.
    reset_and_load(16'h12AF, 1'b0, 4'b0001, 4'b0000);
    cnt0[0] = 0; cnt0[1] = 0; cnt0[2] = 0; cntx = 0;
    for (int c = 0; c < 3*BD; c++) begin
      @(negedge clk);
      if (oAN == 4'b1110) cnt0[c / BD]++;
      if ((c / BD) == 1 && oAN != 4'hF && oAN != 4'b1110) cntx++;
    end
    chk("blink_d0_phase0", cnt0[0], RD - GC);
    chk("blink_d0_phase1_dark", cnt0[1], 0);
    chk("blink_d0_phase0_again", cnt0[2], RD - GC);
    chk("blink_other_digits_phase1", cntx, 3*(RD - GC));

    // Load during digit 1's SHOW and wrap period.
    reset_and_load(16'h12AF, 1'b0, 4'b0000, 4'b0000);
    last_wrap = -1; nwrap = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 11) begin
        iLOAD = 1'b1; iVALUE = 16'h3C7E;
      end
      if (c == 12) begin
        iLOAD = 1'b0;
        chk("midload_old_seg", {25'h0, oSEG}, {25'h0, 7'b0001000});
        chk("midload_an_c12", {28'h0, oAN}, 32'hD);
      end
      if (c == 13) begin
        chk("midload_new_seg", {25'h0, oSEG}, {25'h0, 7'b1111000});
        chk("midload_an_c13", {28'h0, oAN}, 32'hD);
      end
      if (oSCAN_WRAP) begin
        if (last_wrap < 0) chk("first_wrap_cycle", c, RD*ND - 1);
        else               chk("wrap_period", c - last_wrap, RD*ND);
        last_wrap = c;
        nwrap++;
      end
    end
    chk("wrap_count", nwrap, 3);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits (range 2-8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit is selected (minimum 4).
REQ-003 SHALL have parameter GUARD_CYCLES, default 2: anode-off cycles at the start of each digit slot (must be less than REFRESH_DIV).
REQ-004 SHALL have parameter BLINK_DIV, default 12500000: clock cycles per blink half-period.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port iVALUE, input, 4*NUM_DIGITS bits: hex nibbles, where digit 0 is the least significant nibble.
REQ-008 SHALL have port iLOAD, input, 1 bit: captures iVALUE, iBLINK and iLZS when high.
REQ-009 SHALL have port iBLINK, input, NUM_DIGITS bits: per-digit blink enable.
REQ-010 SHALL have port iLZS, input, 1 bit: leading-zero suppression enable.
REQ-011 SHALL have port iDP, input, NUM_DIGITS bits: per-digit decimal point, active high, not latched (live).
REQ-012 SHALL have port oSEG, output, 7 bits: segments a..g, active low, with bit 0 = a.
REQ-013 SHALL have port oDP, output, 1 bit: decimal point, active low.
REQ-014 SHALL have port oAN, output, NUM_DIGITS bits: digit anodes, active low, one-hot-or-none.
REQ-015 SHALL have port oSCAN_WRAP, output, 1 bit: one-cycle pulse when the digit index wraps from NUM_DIGITS-1 to 0.

Function
REQ-016 SHALL latch iVALUE, iBLINK and iLZS into shadow registers on any clock edge with iLOAD=1; the shadow values are used from the next cycle.
REQ-017 SHALL have a slot counter that counts 0..REFRESH_DIV-1 and wraps to 0; on wrap, the digit index advances by 1 modulo NUM_DIGITS.
REQ-018 SHALL assert oSCAN_WRAP for exactly one cycle, coincident with the index register changing from NUM_DIGITS-1 to 0.
REQ-019 SHALL run a two-state slot FSM: GUARD while slot counter < GUARD_CYCLES, otherwise SHOW.
REQ-020 SHALL drive oAN all ones and oSEG/oDP all ones (off) in GUARD.
REQ-021 SHALL, in SHOW, drive only the selected digit's anode low and oSEG with the hex pattern of the selected nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 SHALL drive oAN, oSEG and oDP from registers, with one cycle of latency from the slot counter/index state to the pins.
REQ-023 SHALL, when shadow LZS=1, force any digit above the most significant non-zero nibble off (anode high); digit 0 is never suppressed, so a value of 0 shows "0".
REQ-024 SHALL have a blink counter that counts 0..BLINK_DIV-1 and toggles blink_phase on wrap; the counter is free-running and independent of iLOAD.
REQ-025 SHALL force a digit off (anode high) in SHOW when blink_phase=1 and its shadow iBLINK bit is 1.
REQ-026 SHALL keep the suppressed or blinked-off condition on oDP as well; oDP is otherwise the inverse of iDP[index].
REQ-027 SHALL keep the counters running when iLOAD occurs mid-slot; a new value appears on the current digit from the next cycle, with no restart of the scan.
REQ-028 SHALL size counter widths with $clog2 of their divisors; no counter may exceed its terminal value.

Reset
REQ-029 SHALL, on reset=1 at a clock edge: slot counter, blink counter, index and blink_phase go to 0; shadow value, blink and LZS go to 0; oAN, oSEG and oDP go to all ones; oSCAN_WRAP goes to 0.
REQ-030 SHALL give reset priority over iLOAD when both are asserted in the same cycle.
REQ-031 SHALL begin a GUARD slot for digit 0 on the first cycle after reset is released.

Structure
REQ-032 SHALL place the segment pattern constants, the slot-state enum and the default parameter values in package seg7_pkg.
REQ-033 SHALL use a combinational sub-module, seg7_hex_lut (4-bit in, 7-bit active-low out), instantiated once on the selected nibble.

Verification
REQ-034 SHALL verify: with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, load 0x12AF with LZS=0 -> oAN cycles 1110, 1101, 1011, 0111 and oSEG shows F=0001110, A=0001000, 2=0100100, 1=1111001, with 6 SHOW cycles per slot.
REQ-035 SHALL verify: load 0x0030 with LZS=1 -> digits 3 and 2 are always anode high, digit 1 shows 3=0110000 and digit 0 shows 0=1000000.
REQ-036 SHALL verify: load 0x0000 with LZS=1 -> only digit 0 is lit, showing 1000000.
REQ-037 SHALL verify: BLINK_DIV=32 and iBLINK=0001 -> digit 0 is dark for the 32 cycles while blink_phase=1 and lit in the next 32, while digits 1-3 are unaffected.
REQ-038 SHALL verify: assert reset mid-SHOW on digit 2 -> the next cycle has oAN=1111 and oSEG=1111111, and after release the first lit digit is 0 after exactly GUARD_CYCLES+1 cycles.
REQ-039 SHALL verify: iLOAD with a new value during digit 1's SHOW -> oSEG changes one cycle later with no oAN glitch, and oSCAN_WRAP keeps its period of 32 cycles.
